data_mem_ctrl: RTL and testbench

- Parametrised data memory for the MIPS datapath; successor to the single-cycle word-only data RAM.
- Adds byte/halfword/word access with little-endian lane selection and sign/zero extension on loads.
- Adds a req/ready/done handshake with a configurable number of wait states, and an error response for misaligned, out-of-range or reserved-size accesses.
- Keeps a debug tap of word 0 for board display.

---
 rtl/data_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data memory controller for the MIPS datapath: byte/half/word access with
// little-endian lanes, load extension, req/ready/done handshake and error response.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1,
    parameter int TEST_W      = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              req,
    output logic              ready,
    input  logic [ADDR_W-1:0] A,
    input  logic              WE,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       WD,
    output logic [31:0]       RD,
    output logic              done,
    output logic              err,
    output logic [TEST_W-1:0] test_value
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAST_CNT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [ADDR_W-3:0] IDX_LIMIT = (ADDR_W-2)'(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] a_q;
    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [31:0]       wd_q, rd_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              idle, enter_done;
    logic [ADDR_W-1:0] acc_a;
    logic              acc_we, acc_uns, acc_err;
    logic [1:0]        acc_size;
    logic [31:0]       acc_wd, rd_word, ld_word, wr_word;
    logic [15:0]       ld_lane;
    logic [ADDR_W-3:0] acc_idx;
    logic [IDX_W-1:0]  mem_idx;

    assign idle = (state_q == S_IDLE);

    // With zero wait states the RAM access happens on the acceptance edge itself,
    // so the access is decoded from the live inputs while idle, else from the latch.
    assign acc_a    = idle ? A    : a_q;
    assign acc_we   = idle ? WE   : we_q;
    assign acc_size = idle ? size : size_q;
    assign acc_uns  = idle ? uns  : uns_q;
    assign acc_wd   = idle ? WD   : wd_q;

    assign acc_idx = acc_a[ADDR_W-1:2];
    assign mem_idx = acc_idx[IDX_W-1:0];
    assign rd_word = mem_q[mem_idx];
    assign ld_lane = 16'(rd_word >> {acc_a[1:0], 3'b000});

    assign acc_err = (acc_size == 2'b11)
                   || (acc_size == 2'b01 && acc_a[0])
                   || (acc_size == 2'b10 && acc_a[1:0] != 2'b00)
                   || (acc_idx >= IDX_LIMIT);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d = '0;
                    if (WAIT_STATES == 0) state_d = S_DONE;
                    else                  state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) state_d = S_DONE;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_done = (state_d == S_DONE);

    always_comb begin
        ld_word = rd_word;
        case (acc_size)
            2'b00:   ld_word = acc_uns ? {24'b0, ld_lane[7:0]} : {{24{ld_lane[7]}}, ld_lane[7:0]};
            2'b01:   ld_word = acc_uns ? {16'b0, ld_lane} : {{16{ld_lane[15]}}, ld_lane};
            default: ld_word = rd_word;
        endcase
    end

    always_comb begin
        wr_word = rd_word;
        case (acc_size)
            2'b00:   wr_word[{acc_a[1:0], 3'b000} +: 8] = acc_wd[7:0];
            2'b01:   wr_word[{acc_a[1], 4'b0000} +: 16] = acc_wd[15:0];
            2'b10:   wr_word = acc_wd;
            default: wr_word = rd_word;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            // NOTE: the RAM itself is cleared on reset, which forces a flop array
            // rather than a block RAM; board software relies on a zeroed memory.
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= enter_done && acc_err;
            if (idle && req) begin
                a_q    <= A;
                we_q   <= WE;
                size_q <= size;
                uns_q  <= uns;
                wd_q   <= WD;
            end
            if (enter_done) begin
                if (acc_err)     rd_q             <= '0;
                else if (acc_we) mem_q[mem_idx]   <= wr_word;
                else             rd_q             <= ld_word;
            end
        end
    end

    assign ready      = idle;
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign RD         = rd_q;
    assign test_value = mem_q[0][TEST_W-1:0];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances with 1, 3 and 0 wait states
// share the data inputs; each access pushes its expectation and pops it on done.
module tb_data_mem_ctrl;

    localparam int DEPTH = 256;
    localparam int WS [3] = '{1, 3, 0};

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        err;
        logic        chk_tv;
        logic [15:0] tv;
    } exp_t;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_v = '0;
    logic [2:0]  ready_v, done_v, err_v;
    logic [31:0] A = '0;
    logic        WE = 1'b0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0;
    logic [31:0] WD = '0;
    logic [31:0] rd_v [3];
    logic [15:0] tv_v [3];

    logic [31:0] mem_m [3][DEPTH];
    logic [31:0] rd_m [3];
    exp_t        sb_q [$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_STATES(1), .TEST_W(16)) u_dut_w1 (
        .CLK(CLK), .rst(rst), .req(req_v[0]), .ready(ready_v[0]), .A(A), .WE(WE),
        .size(size), .uns(uns), .WD(WD), .RD(rd_v[0]), .done(done_v[0]), .err(err_v[0]),
        .test_value(tv_v[0]));

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_STATES(3), .TEST_W(16)) u_dut_w3 (
        .CLK(CLK), .rst(rst), .req(req_v[1]), .ready(ready_v[1]), .A(A), .WE(WE),
        .size(size), .uns(uns), .WD(WD), .RD(rd_v[1]), .done(done_v[1]), .err(err_v[1]),
        .test_value(tv_v[1]));

    data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_STATES(0), .TEST_W(16)) u_dut_w0 (
        .CLK(CLK), .rst(rst), .req(req_v[2]), .ready(ready_v[2]), .A(A), .WE(WE),
        .size(size), .uns(uns), .WD(WD), .RD(rd_v[2]), .done(done_v[2]), .err(err_v[2]),
        .test_value(tv_v[2]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++) begin
            rd_m[s] = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[s][i] = '0;
        end
    endtask

    // Called at a falling edge with the selected instance idle.
    task automatic access(input int s, input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        exp_t        e;
        logic        bad;
        logic [31:0] w, r, b;
        int          idx, cyc;
        bit          seen;
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || (a[31:2] >= 30'(DEPTH));
        idx = bad ? 0 : int'(a[31:2]);
        w   = mem_m[s][idx];
        r   = rd_m[s];
        if (bad) r = '0;
        else if (we) begin
            case (sz)
                2'b00: w = (w & ~(32'hFF << (8 * a[1:0]))) | ((wd & 32'hFF) << (8 * a[1:0]));
                2'b01: w = (w & ~(32'hFFFF << (16 * a[1]))) | ((wd & 32'hFFFF) << (16 * a[1]));
                default: w = wd;
            endcase
            mem_m[s][idx] = w;
        end else begin
            case (sz)
                2'b00: begin
                    b = (w >> (8 * a[1:0])) & 32'hFF;
                    r = (!u && b[7]) ? (b | 32'hFFFFFF00) : b;
                end
                2'b01: begin
                    b = (w >> (16 * a[1])) & 32'hFFFF;
                    r = (!u && b[15]) ? (b | 32'hFFFF0000) : b;
                end
                default: r = w;
            endcase
        end
        rd_m[s]  = r;
        e.tag    = tag;
        e.rd     = r;
        e.err    = bad;
        e.chk_tv = we && !bad && idx == 0;
        e.tv     = mem_m[s][0][15:0];
        sb_q.push_back(e);

        check({tag, "_ready_idle"}, 32'(ready_v[s]), 32'd1);
        A = a; WE = we; size = sz; uns = u; WD = wd; req_v[s] = 1'b1;
        @(negedge CLK);
        req_v[s] = 1'b0;
        A = $urandom; WE = 1'($urandom); size = 2'($urandom); uns = 1'($urandom); WD = $urandom;
        cyc  = 1;
        seen = 0;
        while (!seen && cyc <= 20) begin
            if (done_v[s]) seen = 1;
            else begin
                check({tag, "_busy_ready"}, 32'(ready_v[s]), 32'd0);
                @(negedge CLK);
                cyc++;
            end
        end
        e = sb_q.pop_front();
        if (!seen) begin
            check({e.tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({e.tag, "_latency"}, 32'(cyc), 32'(WS[s] + 1));
        check({e.tag, "_busy_in_done"}, 32'(ready_v[s]), 32'd0);
        check({e.tag, "_err"}, 32'(err_v[s]), 32'(e.err));
        check({e.tag, "_rd"}, rd_v[s], e.rd);
        if (e.chk_tv) check({e.tag, "_test_value"}, 32'(tv_v[s]), 32'(e.tv));
        @(negedge CLK);
        check({e.tag, "_done_pulse"}, 32'(done_v[s]), 32'd0);
        check({e.tag, "_err_clear"}, 32'(err_v[s]), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge CLK);
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got_done;
        clear_model();
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("por_ready%0d", s), 32'(ready_v[s]), 32'd1);
            check($sformatf("por_done%0d", s), 32'(done_v[s]), 32'd0);
            check($sformatf("por_rd%0d", s), rd_v[s], 32'd0);
        end

        // Reset after arbitrary prior activity.
        access(0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h1111_2222, "pre_sw0");
        access(0, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, "pre_sw8");
        access(0, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, "pre_lw8");
        do_reset(2);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_ready%0d", s), 32'(ready_v[s]), 32'd1);
            check($sformatf("rst_done%0d", s), 32'(done_v[s]), 32'd0);
            check($sformatf("rst_rd%0d", s), rd_v[s], 32'd0);
            check($sformatf("rst_tv%0d", s), 32'(tv_v[s]), 32'd0);
        end
        access(0, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, "rst_lw8");

        // Word, byte and half accesses with one wait state.
        access(0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, "sw10");
        access(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, "lw10");
        access(0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h1234_5680, "sb11");
        access(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, "lw10_after_sb");
        check("sb_merge_const", rd_v[0], 32'hDEAD_80EF);
        access(0, 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0, "lb11");
        check("lb_const", rd_v[0], 32'hFFFF_FF80);
        access(0, 1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0, "lbu11");
        check("lbu_const", rd_v[0], 32'h0000_0080);
        access(0, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, "lh12");
        check("lh_const", rd_v[0], 32'hFFFF_DEAD);
        access(0, 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, "lhu12");
        access(0, 1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'hFFFF_8001, "sh16");
        access(0, 1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0, "lw14");
        access(0, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, "lb13");
        access(0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0000_5A5A, "sw0_tv");

        // Error responses.
        access(0, 1'b0, 2'b01, 1'b0, 32'h0000_0013, 32'h0, "lh13_misalign");
        access(0, 1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'hFFFF_FFFF, "sw6_misalign");
        access(0, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, "lw4_unchanged");
        access(0, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, "size11");
        access(0, 1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h0, "size11_store");
        access(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, "lw10_after_errs");
        access(0, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, "lw_oob");
        access(0, 1'b1, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'h8765_4321, "sw_last");
        access(0, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'h0, "lw_last");
        access(0, 1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'hAA, "sb_high_oob");

        // Zero wait states: done the cycle after acceptance, test_value follows.
        access(2, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0000_ABCD, "w0_sw0");
        access(2, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, "w0_lb1");
        access(2, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_7EEE, "w0_sh2");
        access(2, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, "w0_lw0");
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 63))
                                             : 32'($urandom_range(0, 63));
            access(2, 1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom,
                   $sformatf("w0_rand%0d", i));
        end

        // Three wait states, then reset during WAIT aborts the store.
        access(1, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, "w3_sw20");
        access(1, 1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0, "w3_lh20");
        A = 32'h0; WE = 1'b1; size = 2'b10; uns = 1'b0; WD = 32'h1234_5678; req_v[1] = 1'b1;
        @(negedge CLK);
        req_v[1] = 1'b0;
        check("abort_in_wait", 32'(ready_v[1]), 32'd0);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        clear_model();
        got_done = 0;
        repeat (8) begin
            if (done_v[1]) got_done = 1;
            @(negedge CLK);
        end
        check("abort_no_done", 32'(got_done), 32'd0);
        check("abort_tv", 32'(tv_v[1]), 32'd0);
        access(1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, "abort_lw0");
        check("abort_ram0_const", rd_v[1], 32'd0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
